uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_rx_sync_fifo.sv | 55 +++++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver slice.
//   state_t           receiver FSM states
//   BIT_TIME_DEFAULT  bit divider terminal count (434 clocks/bit)
//   REG_DATA/REG_STAT register byte offsets on the CPU bus
//   ST_*              status register bit positions
//   status_word()     packs the status register read value
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  localparam int BIT_TIME_DEFAULT = 433;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam int ST_DR = 0;
  localparam int ST_OE = 1;
  localparam int ST_FE = 3;

  // Bits 14:13 always read as 1 so the TX-empty flags of a combined
  // RX/TX map look "ready" to software that polls this word.
  function automatic logic [31:0] status_word(input logic dr, input logic oe, input logic fe);
    logic [31:0] w;
    w        = 32'h0000_6000;
    w[ST_DR] = dr;
    w[ST_OE] = oe;
    w[ST_FE] = fe;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU bus handshake shared with the UART transmitter.
//   addr   register select (only bit 2 decoded)
//   din    write data
//   dout   registered read data
//   wr     1 = write, 0 = read
//   valid  access strobe, one access per high cycle
interface uart_rx_if;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        wr;
  logic        valid;

  modport master (output addr, din, wr, valid, input dout);
  modport slave  (input addr, din, wr, valid, output dout);
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: single-clock FIFO, reusable for both RX and TX paths.
//   clk, rst_n  clock, async active-low reset (pointers only)
//   push, din   write request and data
//   pop         read request; head shows the oldest entry
//   full, empty occupancy flags
//   drop        push was refused because the FIFO was full
// A push and a pop in the same cycle while full are both accepted.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointers wrap naturally; only they need reset, storage does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a simultaneous pop reads the old head before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a receive FIFO.
//   clk, rst_n  system clock, async active-low reset
//   bus         CPU register port (slave side of uart_rx_if)
//   rxd         asynchronous serial input, idle high
// Registers: data (addr[2]=0, read pops the FIFO) and status
// (addr[2]=1, read DR/OE/FE; write din[1]/din[3] clears OE/FE).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BIT_TIME   = BIT_TIME_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus,
  input  logic     rxd
);

  localparam int DW = $clog2(BIT_TIME + 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BIT_TIME / 2);
  localparam logic [DW-1:0] DIV_END  = DW'(BIT_TIME);

  state_t      state, state_next;
  logic [DW-1:0] div, div_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  shreg, shreg_next;
  logic        rx_meta, rxs;
  logic        push_req, fe_set;
  logic        oe, fe;
  logic [31:0] dout_q;

  logic        rd, stat_sel, stat_wr, pop_req;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic        unused_bus;

  assign rd         = bus.valid && !bus.wr;
  assign stat_sel   = bus.addr[2] == REG_STAT[2];
  assign stat_wr    = bus.valid && bus.wr && stat_sel;
  assign pop_req    = rd && !stat_sel;
  assign bus.dout   = dout_q;
  assign unused_bus = ^{bus.addr[1:0], bus.din[31:4], bus.din[2], bus.din[0], fifo_full};

  // Two-flop synchroniser; resets to the idle line level so no false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      div     <= div_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
    end
  end

  // Next-state logic. The start bit is re-checked at half a bit so short
  // glitches are rejected, after which every sample lands mid-bit.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    push_req     = 1'b0;
    fe_set       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) state_next = S_START;
      end
      S_START: begin
        bit_cnt_next = '0;
        if (div == DIV_HALF) state_next = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (div == DIV_END) begin
          shreg_next   = {rxs, shreg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (div == DIV_END) begin
          if (rxs) begin
            push_req   = 1'b1;
            state_next = S_IDLE;
          end else begin
            fe_set     = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state || state == S_IDLE || div == DIV_END) div_next = '0;
    else                                                          div_next = div + 1'b1;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (shreg),
    .pop   (pop_req),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Sticky error flags; a set in the same cycle as a software clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe <= 1'b0;
      fe <= 1'b0;
    end else begin
      if (fifo_drop)                    oe <= 1'b1;
      else if (stat_wr && bus.din[ST_OE]) oe <= 1'b0;
      if (fe_set)                       fe <= 1'b1;
      else if (stat_wr && bus.din[ST_FE]) fe <= 1'b0;
    end
  end

  // Read data register; zero on every cycle that is not a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd) begin
      if (stat_sel)        dout_q <= status_word(!fifo_empty, oe, fe);
      else if (fifo_empty) dout_q <= '0;
      else                 dout_q <= {24'd0, fifo_head};
    end else begin
      dout_q <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Serial frames are generated
// from random or fixed bytes, a queue-based model tracks FIFO contents and
// error flags, and a monitor compares every read response against it.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BT       = 39;
  localparam int NBIT     = BT + 1;
  localparam int HALF     = BT / 2;
  localparam int DEPTH    = 16;
  localparam int PUSH_LAT = HALF + 3 + 9 * NBIT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_if bus();

  uart_rx #(.BIT_TIME(BT), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  model_q[$];
  logic        model_oe = 1'b0;
  logic        model_fe = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Status word as software should see it from the model state.
  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s    = 32'h0000_6000;
    s[0] = (model_q.size() != 0);
    s[1] = model_oe;
    s[3] = model_fe;
    return s;
  endfunction

  // One bus cycle. Reads push their expected response into the scoreboard.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [31:0] d, input string name);
    logic [31:0] e;
    bus.valid = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.din   = d;
    if (!w) begin
      if (a[2])                    e = model_status();
      else if (model_q.size() > 0) e = {24'd0, model_q.pop_front()};
      else                         e = 32'd0;
      exp_q.push_back(e);
      name_q.push_back(name);
    end else if (a[2]) begin
      if (d[1]) model_oe = 1'b0;
      if (d[3]) model_fe = 1'b0;
    end
    @(negedge clk);
    bus.valid = 1'b0;
    bus.wr    = 1'b0;
    bus.din   = 32'd0;
  endtask

  // Drive one 8N1 frame on rxd, LSB first; optionally hold the line low afterwards.
  task automatic sendFrame(input logic [7:0] b, input logic stop_bit, input int hold);
    rxd = 1'b0;
    repeat (NBIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (NBIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (NBIT) @(negedge clk);
    if (!stop_bit) repeat (hold) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Frame plus its effect on the model: good stop queues the byte or overruns.
  task automatic receiveFrame(input logic [7:0] b, input logic stop_bit, input int hold);
    sendFrame(b, stop_bit, hold);
    if (!stop_bit)                 model_fe = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else                           model_oe = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a read accepted at a rising edge shows its data one cycle later;
  // every other cycle must present zero.
  initial begin : monitor
    logic read_seen;
    forever begin
      @(posedge clk);
      read_seen = bus.valid && !bus.wr;
      @(negedge clk);
      if (read_seen) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_read: got %08h expected no response", bus.dout);
        end else begin
          checkOutput(name_q.pop_front(), bus.dout, exp_q.pop_front());
        end
      end else begin
        checkOutput("idle_dout", bus.dout, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [7:0] b;
    logic       stop;
    bus.valid = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 3'd0;
    bus.din   = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dout", bus.dout, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, REG_STAT, 32'd0, "reset_status");
    applyStimulus(1'b0, REG_DATA, 32'd0, "reset_empty_read");

    $display("[TB] single frame");
    receiveFrame(8'hA5, 1'b1, 0);
    gap(5);
    applyStimulus(1'b0, REG_STAT, 32'd0, "a5_status");
    applyStimulus(1'b0, REG_DATA, 32'd0, "a5_data");
    applyStimulus(1'b0, REG_STAT, 32'd0, "a5_status_after");

    $display("[TB] glitch reject");
    rxd = 1'b0;
    gap(HALF / 2);
    rxd = 1'b1;
    gap(3 * NBIT);
    applyStimulus(1'b0, REG_STAT, 32'd0, "glitch_status");
    receiveFrame(8'hC3, 1'b1, 0);
    gap(5);
    applyStimulus(1'b0, REG_DATA, 32'd0, "post_glitch_data");

    $display("[TB] framing error with held-low line");
    receiveFrame(8'h3C, 1'b0, 2000);
    gap(10);
    applyStimulus(1'b0, REG_STAT, 32'd0, "fe_status");
    applyStimulus(1'b0, REG_DATA, 32'd0, "fe_data_empty");
    applyStimulus(1'b1, REG_STAT, 32'd8, "fe_clear");
    applyStimulus(1'b0, REG_STAT, 32'd0, "fe_cleared_status");

    $display("[TB] overrun");
    for (int i = 0; i <= 16; i++) begin
      receiveFrame(8'(i), 1'b1, 0);
      gap($urandom_range(2, 12));
    end
    applyStimulus(1'b0, REG_STAT, 32'd0, "ovr_status");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, REG_DATA, 32'd0, "ovr_data");
    applyStimulus(1'b0, REG_DATA, 32'd0, "ovr_empty_read");
    applyStimulus(1'b1, REG_STAT, 32'd2, "oe_clear");
    applyStimulus(1'b0, REG_STAT, 32'd0, "oe_cleared_status");

    $display("[TB] pop coincident with push while full");
    for (int i = 0; i < DEPTH; i++) begin
      receiveFrame(8'($urandom), 1'b1, 0);
      gap($urandom_range(2, 12));
    end
    applyStimulus(1'b0, REG_STAT, 32'd0, "full_status");
    b = 8'($urandom);
    fork
      sendFrame(b, 1'b1, 0);
    join_none
    gap(PUSH_LAT);
    applyStimulus(1'b0, REG_DATA, 32'd0, "coincident_pop");
    gap(10 * NBIT - PUSH_LAT - 1);
    model_q.push_back(b);
    gap(5);
    applyStimulus(1'b0, REG_STAT, 32'd0, "coincident_status");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, REG_DATA, 32'd0, "wrap_data");
    applyStimulus(1'b0, REG_STAT, 32'd0, "wrap_status");

    $display("[TB] reset mid-frame");
    receiveFrame(8'h11, 1'b1, 0);
    gap(5);
    fork
      sendFrame(8'h77, 1'b1, 0);
    join_none
    gap(4 * NBIT + NBIT / 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe_reset_dout", bus.dout, 32'd0);
    model_q.delete();
    model_oe = 1'b0;
    model_fe = 1'b0;
    gap(6 * NBIT + 5);
    rst_n = 1'b1;
    gap(3);
    applyStimulus(1'b0, REG_STAT, 32'd0, "post_reset_status");
    applyStimulus(1'b0, REG_DATA, 32'd0, "post_reset_empty");
    receiveFrame(8'h5A, 1'b1, 0);
    gap(5);
    applyStimulus(1'b0, REG_DATA, 32'd0, "post_reset_5a");

    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      receiveFrame(b, stop, 0);
      gap($urandom_range(3, 40));
    end
    applyStimulus(1'b0, REG_STAT, 32'd0, "rand_status");
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, REG_STAT, 32'd0, "rand_status_read");
      else                           applyStimulus(1'b0, REG_DATA, 32'd0, "rand_data_read");
    end
    applyStimulus(1'b1, REG_STAT, 32'hA, "rand_clear");
    applyStimulus(1'b0, REG_STAT, 32'd0, "rand_final_status");

    gap(3);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL pending_responses: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
